// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and helpers for the binary-to-BCD scheduler
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  // Largest value representable in the given number of BCD digits (10^digits - 1)
  function automatic logic [63:0] bcd_max_value(input int digits);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// rtl/bcd_dabble_step.sv - one combinational double-dabble iteration over DIGITS BCD digits
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic [DIGITS*BCD_DIGIT_W-1:0] digits_in,
  input  logic                          bit_in,
  output logic [DIGITS*BCD_DIGIT_W-1:0] digits_out,
  output logic                          ovf_out
);

  localparam int DW = DIGITS * BCD_DIGIT_W;

  logic [DW-1:0] adj;

  function automatic bcd_digit_t add3(input bcd_digit_t d);
    return (d >= bcd_digit_t'(5)) ? d + bcd_digit_t'(3) : d;
  endfunction

  // Pre-correct every digit that would exceed 9 after doubling
  always_comb begin
    adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      adj[d*BCD_DIGIT_W +: BCD_DIGIT_W] = add3(digits_in[d*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
  end

  // Shift left by one; the bit falling off the top digit means the value no longer fits
  assign digits_out = {adj[DW-2:0], bit_in};
  assign ovf_out    = adj[DW-1];

endmodule

// File: rtl/score_bcd_scheduler.sv
// rtl/score_bcd_scheduler.sv - round-robin scheduler sharing one sequential binary-to-BCD engine
module score_bcd_scheduler
  import bcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BIN_W   = 16,
  parameter int DIGITS  = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BIN_W-1:0]     bin,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_REQ)-1:0]   done_id,
  output logic [DIGITS*BCD_DIGIT_W-1:0] bcd,
  output logic                         ovf
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int DW    = DIGITS * BCD_DIGIT_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   cur;
  logic [BIN_W-1:0] shreg;
  logic [DW-1:0]    work;
  logic             sticky;
  logic [CNT_W-1:0] cnt;

  logic             found;
  logic [IDW-1:0]   gnt;
  int               idx;
  logic [DW-1:0]    step_out;
  logic             step_ovf;

  // Round-robin pick: first active requester at or after the pointer, wrapping
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt   = IDW'(idx);
      end
    end
  end

  bcd_dabble_step #(
    .DIGITS(DIGITS)
  ) u_step (
    .digits_in (work),
    .bit_in    (shreg[BIN_W-1]),
    .digits_out(step_out),
    .ovf_out   (step_ovf)
  );

  // Scheduler FSM; result registers load on the edge entering DONE so they are valid with done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cur     <= '0;
      shreg   <= '0;
      work    <= '0;
      sticky  <= 1'b0;
      cnt     <= '0;
      ack     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      ack  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            shreg    <= bin[gnt*BIN_W +: BIN_W];
            work     <= '0;
            sticky   <= 1'b0;
            cnt      <= CNT_W'(BIN_W);
            cur      <= gnt;
            ptr      <= (gnt == IDW'(NUM_REQ - 1)) ? '0 : gnt + IDW'(1);
            ack[gnt] <= 1'b1;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          shreg  <= {shreg[BIN_W-2:0], 1'b0};
          work   <= step_out;
          sticky <= sticky | step_ovf;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd     <= step_out;
            ovf     <= sticky | step_ovf;
            done_id <= cur;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/score_bcd_scheduler.md
# score_bcd_scheduler

Shares one sequential double-dabble binary-to-BCD engine between several requesters (score, high score, lives, wave counter) feeding the HUD digit renderer. Round-robin arbitration, req/ack handshake on the input side, one-cycle `done` pulse with requester ID and registered BCD digits on the output side. Costs BIN_W+2 cycles per conversion in place of a fully unrolled combinational converter per requester.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- BIN_W, 16, binary operand width
- DIGITS, 5, BCD digits produced; 10^DIGITS-1 below 2^BIN_W-1 allowed, flagged via `ovf`
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- req  in  NUM_REQ  conversion request per requester, level
- bin  in  NUM_REQ*BIN_W  operands, requester i at [i*BIN_W +: BIN_W]
- ack  out  NUM_REQ  one-hot one-cycle pulse: operand i latched
- busy  out  1  high from the cycle after grant through the DONE cycle
- done  out  1  one-cycle pulse: `bcd`, `ovf`, `done_id` valid
- done_id  out  $clog2(NUM_REQ)  requester the result belongs to
- bcd  out  DIGITS*4  result, digit 0 (ones) at [3:0]
- ovf  out  1  value exceeded 10^DIGITS-1 (digits truncated)

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if any `req` is high, grant the first requester at or after `ptr` (round-robin pointer), wrapping. On that edge: latch `bin[g]` into shift register, clear working digits and sticky overflow, load `cnt`=BIN_W, `ptr`<=g+1 mod NUM_REQ, `ack[g]`<=1, go to SHIFT.
- SHIFT, once per cycle: add 3 to each working digit >=5, then shift {digits, operand} left by 1, operand MSB entering digit 0 LSB. A 1 leaving the top digit's MSB sets sticky overflow. `cnt` decrements; SHIFT that consumes the last bit goes to DONE.
- DONE: `bcd`<=working digits, `ovf`<=sticky, `done_id`<=g, `done`=1 for this cycle only; then IDLE.
- `bcd`, `ovf`, `done_id` hold between `done` pulses.
- `req` not sampled outside IDLE. Requester drops `req` in the `ack` cycle; a `req` still high at the next IDLE is a new request (requester sees a repeat conversion).
- `bin[i]` must be stable from `req[i]` rise until `ack[i]`; later changes do not affect the in-flight conversion.
- Reset (rst_n low at an edge, any state): IDLE, `ptr`=0 (requester 0 highest priority), `ack`=0, `done`=0, `busy`=0, `bcd`=0, `ovf`=0, `done_id`=0. In-flight conversion discarded, no `done`.

## Timing
- `req` high in IDLE cycle T -> `ack` high in T+1, SHIFT cycles T+1..T+BIN_W, `done` high in T+BIN_W+1 (T+17 for defaults).
- Earliest next grant: IDLE cycle T+BIN_W+2. Throughput one conversion per BIN_W+2 cycles.
- `busy` high T+1..T+BIN_W+1.
- Simultaneous requests: one grant per IDLE cycle; others wait. With all requesters held high, grant order is 0,1,2,3,0,...
- All outputs registered; no combinational path from `req`/`bin` to any output.

## Structure
- Package `bcd_pkg`: state enum (IDLE, SHIFT, DONE), `BCD_DIGIT_W`=4, `bcd_digit_t` typedef, function for max representable value per DIGITS.
- Sub-module `bcd_dabble_step`: combinational single iteration (add-3 per digit, shift by 1, carry-in bit, overflow-out bit), parameterised by DIGITS. Instantiated once; scheduler holds FSM, arbiter, counter and registers.

## Test plan
- Single `req[1]`, bin=255 -> `ack[1]` at T+1, `done` at T+17, bcd=0x00255, done_id=1, ovf=0.
- `req[0]`, bin=65535 -> bcd=0x65535, ovf=0; bin=0 -> bcd=0x00000.
- `req[0]` and `req[2]` rise together (bins 42, 9001) -> grant 0 first (bcd=0x00042, done_id=0), `req[2]` granted at next IDLE (bcd=0x09001, done_id=2).
- All four `req` held high for 8 conversions -> done_id sequence 0,1,2,3,0,1,2,3, spacing exactly 18 cycles.
- rst_n low for one cycle during SHIFT cycle 8 -> no `done`, all outputs 0 next cycle; new `req[3]`, bin=1234 -> bcd=0x01234, done_id=3.
- DIGITS=3, bin=1000 -> ovf=1, bcd=0x000; bin=999 -> ovf=0, bcd=0x999.
